i8080_bus_cycle_gen: RTL
========================

// Module: i8080_bus_cycle_gen
// PURPOSE
//  Master side of the 8080 system bus: turns a simple one-request-at-a-time port from a soft CPU core
//  into 8080-style machine cycles: status on D at SYNC, STSTB_n strobe, READY wait states, DBIN/WR_n
//  data phase, HOLD/HLDA. Drives the status/control pins that the 8228-style system controller decodes.
// PARAMETERS
//  STSTB_W   1  STSTB_n low width in clocks (1..4); T2 lasts STSTB_W clocks
//  MAX_WAIT  0  wait-state limit; 0 = unlimited, N>0 = abort after N TW clocks
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high
//  req        in   1   level; core holds it with fields stable until done
//  req_status in   8   8080 status byte (D0 INTA, D1 nWO, D3 HLTA, D4 OUT, D6 INP, D7 MEMR)
//  req_addr   in   16  cycle address
//  req_wdata  in   8   write data (used when req_status[1]=0)
//  busy       out  1   cycle in progress (T1..T3)
//  done       out  1   one-clock completion pulse
//  err        out  1   one-clock, with done, when MAX_WAIT abort occurred
//  rdata      out  8   read data, valid from done onward until next read completes
//  a          out  16  address bus
//  a_oe       out  1   address output enable (0 in HOLD)
//  d_out      out  8   data/status to bus
//  d_oe       out  1   d_out enable
//  d_in       in   8   data from bus
//  sync       out  1   high during T1
//  ststb_n    out  1   status strobe, low during T2
//  dbin       out  1   read data phase
//  wr_n       out  1   write strobe, active low
//  ready      in   1   sampled on last T2 clock and every TW clock
//  wait_o     out  1   high in TW
//  hold       in   1   bus request from DMA
//  hlda       out  1   hold acknowledge
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; a=0, a_oe=1, d_out=0, d_oe=0, sync=0, ststb_n=1, dbin=0,
//    wr_n=1, wait_o=0, hlda=0, busy=0, done=0, err=0, rdata=0; in-flight cycle dropped, no done.
//  - States: IDLE, T1, T2, TW, T3, HOLD. Registered outputs; values below hold during the named state.
//  - IDLE: hold=1 -> HOLD (wins over simultaneous req). Else req=1 -> latch status/addr/wdata, -> T1.
//    req is sampled in the same clock done is high (back-to-back allowed).
//  - T1 (1 clk): a=addr, d_out=status, d_oe=1, sync=1, busy=1.
//  - T2 (STSTB_W clks): sync=0, ststb_n=0, d_out=status. On last T2 clock: ready=1 -> T3, else -> TW.
//  - TW: wait_o=1, ststb_n=1; bus otherwise as T3 setup. ready=1 -> T3. Wait counter 0..MAX_WAIT;
//    count reaching MAX_WAIT (MAX_WAIT>0) -> T3 with abort flag set.
//  - T3 (1 clk): read (status[1]=1): d_oe=0, dbin=1, rdata<=d_in at end of T3.
//    write (status[1]=0): d_out=wdata, d_oe=1, wr_n=0. HLTA (status[3]=1): no dbin/wr_n, rdata kept.
//    -> IDLE with done=1 (err=abort flag) for one clock; busy=0, d_oe=0, dbin=0, wr_n=1, a held.
//  - Latency at STSTB_W=1, ready=1: req-sampling edge to done = 4 clocks; period 4 clocks back-to-back.
//  - hold during T1..T3 ignored until IDLE. HOLD: a_oe=0, d_oe=0, hlda=1 one clock after entry;
//    hold=0 -> hlda=0 next clock, back to IDLE (no cycle started in that clock).
//  - ready ignored outside last-T2/TW; d_in ignored except in T3 of reads.
// CONFIGURATION
//  BUS_INTA_RST7_EN defined: INTA cycles (status[0]=1) run T1/T2/T3 but dbin stays 0 and rdata<=8'hFF
//  (RST 7, single-level interrupt, no bus responder needed). Undefined: INTA is a normal read, dbin=1.
// TESTING
//  - Reset mid-T2 (ststb_n=0) -> ststb_n=1, busy=0, a=0 immediately; no done follows.
//  - Mem read status=8'hA2 addr=16'h1234, ready=1, d_in=8'h5A -> sync 1 clk, ststb_n low 1 clk, dbin
//    1 clk, done 4 clks after accept, rdata=8'h5A.
//  - Mem write status=8'h00 wdata=8'h3C, ready low 3 clks -> wait_o 3 clks, wr_n low 1 clk with
//    d_out=8'h3C, done 7 clks after accept.
//  - MAX_WAIT=2, ready stuck 0 -> 2 TW clks then T3, done and err high together.
//  - hold and req both high in IDLE -> hlda=1 next clk, sync stays 0; hold=0 -> hlda=0, then T1 starts.
//  - INTA status=8'h23 with BUS_INTA_RST7_EN, d_in=8'h00 -> dbin never 1, rdata=8'hFF; without: rdata=8'h00.

Source files
------------

// File: rtl/i8080_bus_cycle_gen.sv
// ---------------------------------------------------------------------------
// i8080_bus_cycle_gen
//   Bus master for an 8080-style system bus. A soft core presents one request
//   at a time (req held with stable fields until done). The block runs the
//   machine cycle as T1 (SYNC, status on D), T2 (STSTB_n low for STSTB_W
//   clocks), optional TW wait states driven by READY, and T3 (DBIN read or
//   WR_n write). HOLD/HLDA hands the bus to a DMA master while idle.
//
// Parameters
//   STSTB_W   : STSTB_n low width in clocks (1..4), equals the T2 length
//   MAX_WAIT  : wait-state limit, 0 = unlimited, N>0 = abort after N TW clocks
//
// Ports
//   clk, reset              : clock, asynchronous active-high reset
//   req, req_status,
//   req_addr, req_wdata     : core request (status byte, address, write data)
//   busy, done, err, rdata  : core response
//   a, a_oe, d_out, d_oe,
//   d_in                    : address / data bus
//   sync, ststb_n, dbin,
//   wr_n, ready, wait_o     : bus control
//   hold, hlda              : DMA bus request / acknowledge
//
// Configuration macro
//   BUS_INTA_RST7_EN : INTA cycles return 8'hFF (RST 7) without driving DBIN.
// ---------------------------------------------------------------------------
module i8080_bus_cycle_gen #(
  parameter int STSTB_W  = 1,
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [7:0]  req_status,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] a,
  output logic        a_oe,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        sync,
  output logic        ststb_n,
  output logic        dbin,
  output logic        wr_n,
  input  logic        ready,
  output logic        wait_o,
  input  logic        hold,
  output logic        hlda
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_HOLD} state_e;

  localparam logic [1:0] T2_LAST = 2'(STSTB_W - 1);
  localparam int         WCW     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam bit         W_LIMIT = (MAX_WAIT > 0);

  state_e         state_q;
  logic [7:0]     st_q;
  logic [15:0]    addr_q;
  logic [7:0]     wdata_q;
  logic [1:0]     t2cnt_q;
  logic [WCW-1:0] wcnt_q;
  logic           abort_q;

  logic        busy_q, done_q, err_q, a_oe_q, d_oe_q, sync_q, ststb_n_q;
  logic        dbin_q, wr_n_q, wait_q, hlda_q;
  logic [7:0]  rdata_q, d_out_q;
  logic [15:0] a_q;

  // Cycle classification from the latched status byte.
  logic is_rd, is_hlta, inta7;
  assign is_rd   = st_q[1];
  assign is_hlta = st_q[3];
`ifdef BUS_INTA_RST7_EN
  assign inta7   = st_q[0];
`else
  assign inta7   = 1'b0;
`endif

  // Data-phase drive, used both in TW (setup) and T3.
  logic       dp_doe;
  logic [7:0] dp_dout;
  logic       t3_dbin, t3_wr_n;
  assign dp_doe  = ~is_rd;
  assign dp_dout = is_rd ? st_q : wdata_q;
  assign t3_dbin = is_rd & ~is_hlta & ~inta7;
  assign t3_wr_n = is_rd | is_hlta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      st_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      t2cnt_q   <= '0;
      wcnt_q    <= '0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      a_q       <= '0;
      a_oe_q    <= 1'b1;
      d_out_q   <= '0;
      d_oe_q    <= 1'b0;
      sync_q    <= 1'b0;
      ststb_n_q <= 1'b1;
      dbin_q    <= 1'b0;
      wr_n_q    <= 1'b1;
      wait_q    <= 1'b0;
      hlda_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // hold has priority over a pending request
          if (hold) begin
            state_q <= S_HOLD;
            a_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            hlda_q  <= 1'b1;
          end else if (req) begin
            state_q <= S_T1;
            st_q    <= req_status;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            abort_q <= 1'b0;
            a_q     <= req_addr;
            d_out_q <= req_status;
            d_oe_q  <= 1'b1;
            sync_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_T1: begin
          state_q   <= S_T2;
          sync_q    <= 1'b0;
          ststb_n_q <= 1'b0;
          t2cnt_q   <= '0;
        end
        S_T2: begin
          if (t2cnt_q == T2_LAST) begin
            ststb_n_q <= 1'b1;
            wcnt_q    <= '0;
            d_oe_q    <= dp_doe;
            d_out_q   <= dp_dout;
            if (ready) begin
              state_q <= S_T3;
              dbin_q  <= t3_dbin;
              wr_n_q  <= t3_wr_n;
            end else begin
              state_q <= S_TW;
              wait_q  <= 1'b1;
            end
          end else begin
            t2cnt_q <= t2cnt_q + 2'd1;
          end
        end
        S_TW: begin
          // ready wins over the limit in the same clock
          if (ready || (W_LIMIT && wcnt_q == W_LAST)) begin
            state_q <= S_T3;
            wait_q  <= 1'b0;
            dbin_q  <= t3_dbin;
            wr_n_q  <= t3_wr_n;
            abort_q <= ~ready;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_T3: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
          err_q   <= abort_q;
          busy_q  <= 1'b0;
          d_oe_q  <= 1'b0;
          dbin_q  <= 1'b0;
          wr_n_q  <= 1'b1;
          if (is_rd && !is_hlta)
            rdata_q <= inta7 ? 8'hFF : d_in;
        end
        S_HOLD: begin
          if (!hold) begin
            state_q <= S_IDLE;
            hlda_q  <= 1'b0;
            a_oe_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign a       = a_q;
  assign a_oe    = a_oe_q;
  assign d_out   = d_out_q;
  assign d_oe    = d_oe_q;
  assign sync    = sync_q;
  assign ststb_n = ststb_n_q;
  assign dbin    = dbin_q;
  assign wr_n    = wr_n_q;
  assign wait_o  = wait_q;
  assign hlda    = hlda_q;

endmodule
